controller_driver: RTL and testbench
====================================

Name: controller_driver

Overview:
- Physical-interface stage for the LCD 1602A, directly downstream of the control FSM.
- Accepts one byte per handshake: an instruction (RS=0) or data (RS=1). Serialises it onto the HD44780 bus as two 4-bit nibbles, or as one 8-bit strobe, meeting E/RS setup, pulse-width and execution timing.
- Timing comes from the shared delay counter through its checkpoint flags.
- Returns a one-cycle ready pulse to the control FSM when the byte has been transferred and the 42us execution time has elapsed.

Parameters:
- NFLAGS, 7, width of flags_in; flag indices are f_15000us=0, f_4100us=1, f_1640us=2, f_100us=3, f_42us=4, f_250ns=5, f_40ns=6.
- MODE, 1, bus mode: 0 = 8-bit single strobe, 1 = 4-bit two-nibble transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  transfer request from control (ctrl_enable_driver)
- sel_data  in  2  data-mux select from control: 2'b10 = external data (RS=1), 2'b01 = internal command (RS=0), 2'b00 = unused
- data_in  in  8  byte to send (muxed ctrl_cmd or external data)
- flags_in  in  NFLAGS  delay-counter checkpoints; bit k is high while count >= checkpoint k
- ndrv_count  out  1  counter clear: 1 holds the shared counter at 0, 0 lets it run
- drv_rdy  out  1  one-cycle pulse: byte complete (feeds control driver_rdy)
- drv_abort  out  1  one-cycle pulse: enable was lost during a transfer
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied 0 (write only)
- lcd_db  out  8  LCD data bus; in MODE=1 only [7:4] carry data and [3:0] are driven 0

Behaviour:
- Reset values, applied while rst=1 regardless of state: state=IDLE, ndrv_count=1, drv_rdy=0, drv_abort=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, latched byte=0, latched RS=0, abort flag=0.
- All outputs are registered.
- Wait rule: a timed state advances only when flags_in[k]=1 and ndrv_count=0.
  - ndrv_count is 1 for the single entry cycle of every timed state, which clears the counter, and 0 for the rest of the state.
  - ndrv_count is 1 in IDLE, DONE and RELEASE.
- States:
  - IDLE:
    - lcd_e=0.
    - On enable=1 and sel_data!=2'b00: latch data_in, latch RS = sel_data[1], go to SETUP_H.
    - enable=1 with sel_data=2'b00 is ignored; stay in IDLE.
  - SETUP_H:
    - Drive lcd_rs, lcd_rw=0 and lcd_db (high nibble, or the full byte in MODE=0); lcd_e=0.
    - Wait f_40ns, then go to EHI_H.
  - EHI_H: lcd_e=1, bus held. Wait f_250ns, then go to ELO_H.
  - ELO_H:
    - lcd_e=0, bus held; wait f_250ns.
    - Then go to SETUP_L if MODE=1, or to EXEC if MODE=0.
  - SETUP_L: lcd_db[7:4] = low nibble, lcd_e=0. Wait f_40ns, then go to EHI_L.
  - EHI_L: lcd_e=1. Wait f_250ns, then go to ELO_L.
  - ELO_L: lcd_e=0. Wait f_250ns, then go to EXEC.
  - EXEC: bus held, lcd_e=0. Wait f_42us, then go to DONE.
  - DONE:
    - Exactly one cycle.
    - If the abort flag is clear, drv_rdy=1; if it is set, drv_abort=1 and drv_rdy=0.
    - Next state is RELEASE.
  - RELEASE:
    - drv_rdy=0.
    - Stay until enable=0, then go to IDLE and clear the abort flag.
    - This guarantees that an enable held high, or late by one cycle, never restarts the same byte.
- Handshake timing: latency from enable sampled high in IDLE to the drv_rdy pulse is fixed by the flags: 4-bit = 2x(40ns+250ns+250ns)+42us; 8-bit = 40ns+250ns+250ns+42us, plus one entry cycle per timed state.
- Changes to data_in and sel_data after the latch have no effect until the next IDLE.
- Enable lost mid-transfer (enable=0 in any state from SETUP_H through EXEC):
  - Set the abort flag.
  - The transfer still runs to completion, so the LCD is never left between nibbles.
  - DONE then issues drv_abort instead of drv_rdy.
- Simultaneous events: rst has priority over everything. A flag reaching threshold on the entry cycle is ignored by the ndrv_count=0 qualifier.

Decomposition:
- Shared package/include for:
  - flag indices (f_40ns..f_15000us)
  - sel_data codes (EXTERNAL_DATA, INTERNAL_CMD, UNUSED_DATA)
  - LCD command byte constants (SETUP, DISP_ON, CLEAR_CMD, ENTRY_MODE, ...)
  - driver state encodings
- These replace the local copies in the control block.
- One sub-module is natural: controller_nibble_strobe, which does setup/E-high/E-low for one nibble. It is instantiated once and sequenced twice by the top FSM.

Test Plan:
- MODE=1, sel_data=01, data_in=8'h28, enable held:
  - lcd_rs=0.
  - lcd_db[7:4]=4'h2 with one E pulse, then 4'h8 with one E pulse.
  - Each E pulse is high until f_250ns.
  - drv_rdy pulses once, after f_42us.
- sel_data=10, data_in=8'h41: lcd_rs=1 throughout; nibbles 4, then 1; single drv_rdy.
- enable kept high for 3 cycles after drv_rdy: exactly one transfer (two E pulses), FSM parked in RELEASE; enable low -> IDLE, ndrv_count=1.
- enable dropped during EHI_H: both nibbles still strobed; drv_abort=1 for one cycle; drv_rdy never asserted.
- rst asserted during EHI_L: next cycle lcd_e=0, lcd_db=0, ndrv_count=1, state=IDLE; with enable=0, no E pulse follows.
- MODE=0, data_in=8'h01: single E strobe with lcd_db=8'h01; drv_rdy after f_42us; lcd_rw=0 throughout.

Source files
------------

// File: rtl/controller_driver_pkg.sv
// controller_driver_pkg
// Shared definitions for the LCD 1602A control path: delay-counter flag
// indices, data-mux select codes, HD44780 command bytes, driver state
// encoding and the per-nibble strobe phase encoding.
package controller_driver_pkg;

    // Delay-counter checkpoint indices into flags_in
    localparam int F_15000US = 0;
    localparam int F_4100US  = 1;
    localparam int F_1640US  = 2;
    localparam int F_100US   = 3;
    localparam int F_42US    = 4;
    localparam int F_250NS   = 5;
    localparam int F_40NS    = 6;

    typedef logic [2:0] flag_idx_t;

    // Data-mux select codes (bit 1 doubles as the RS value)
    localparam logic [1:0] EXTERNAL_DATA = 2'b10;
    localparam logic [1:0] INTERNAL_CMD  = 2'b01;
    localparam logic [1:0] UNUSED_DATA   = 2'b00;

    // HD44780 command bytes used by the control FSM
    localparam logic [7:0] SETUP       = 8'h28;  // function set: 4-bit, 2 lines, 5x8
    localparam logic [7:0] SETUP_8BIT  = 8'h38;  // function set: 8-bit, 2 lines, 5x8
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] DISP_OFF    = 8'h08;
    localparam logic [7:0] CLEAR_CMD   = 8'h01;
    localparam logic [7:0] RETURN_HOME = 8'h02;
    localparam logic [7:0] ENTRY_MODE  = 8'h06;

    typedef enum logic [3:0] {
        IDLE,
        SETUP_H,
        EHI_H,
        ELO_H,
        SETUP_L,
        EHI_L,
        ELO_L,
        EXEC,
        DONE,
        RELEASE
    } drv_state_t;

    // Phase of a single nibble strobe; both nibbles share the same phases
    typedef enum logic [1:0] {
        PH_NONE,
        PH_SETUP,
        PH_EHI,
        PH_ELO
    } strobe_phase_t;

    function automatic strobe_phase_t phase_of(drv_state_t s);
        case (s)
            SETUP_H, SETUP_L: return PH_SETUP;
            EHI_H, EHI_L:     return PH_EHI;
            ELO_H, ELO_L:     return PH_ELO;
            default:          return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/controller_nibble_strobe.sv
// controller_nibble_strobe
// Timing for one nibble transfer (setup -> E high -> E low). The top FSM
// walks through these phases twice in 4-bit mode, once in 8-bit mode.
// Ports:
//   phase      in  phase of the current driver state
//   phase_next in  phase of the state being entered next cycle
//   flags      in  delay-counter checkpoint flags
//   cnt_clear  in  registered counter clear; blocks the entry cycle
//   advance    out current phase's wait has elapsed
//   e_next     out E level for the state being entered
module controller_nibble_strobe
    import controller_driver_pkg::*;
#(
    parameter int NFLAGS = 7
) (
    input  strobe_phase_t     phase,
    input  strobe_phase_t     phase_next,
    input  logic [NFLAGS-1:0] flags,
    input  logic              cnt_clear,
    output logic              advance,
    output logic              e_next
);

    flag_idx_t wait_sel;

    always_comb begin
        // Setup waits for address/data setup time, both E phases for 250ns
        wait_sel = flag_idx_t'(F_250NS);
        if (phase == PH_SETUP) begin
            wait_sel = flag_idx_t'(F_40NS);
        end
        // The counter was being cleared on the entry cycle, so its flags
        // still reflect the previous state and must be ignored.
        advance = (phase != PH_NONE) && !cnt_clear && flags[wait_sel];
        e_next  = (phase_next == PH_EHI);
    end

endmodule

// File: rtl/controller_driver.sv
// controller_driver
// Physical-interface stage for the LCD 1602A: takes one byte per handshake
// and serialises it onto the HD44780 bus (two nibbles when MODE=1, one
// 8-bit strobe when MODE=0), then waits out the 42us execution time.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   enable      transfer request from control
//   sel_data    2'b10 data (RS=1), 2'b01 command (RS=0), 2'b00 ignored
//   data_in     byte to send
//   flags_in    delay-counter checkpoints
//   ndrv_count  1 holds the shared delay counter at 0
//   drv_rdy     one-cycle pulse: byte complete
//   drv_abort   one-cycle pulse: enable dropped during the transfer
//   lcd_e/lcd_rs/lcd_rw/lcd_db  HD44780 bus (all registered)
module controller_driver
    import controller_driver_pkg::*;
#(
    parameter int NFLAGS = 7,
    parameter int MODE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        sel_data,
    input  logic [7:0]        data_in,
    input  logic [NFLAGS-1:0] flags_in,
    output logic              ndrv_count,
    output logic              drv_rdy,
    output logic              drv_abort,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [7:0]        lcd_db
);

    drv_state_t    state_reg, state_next;
    logic [7:0]    byte_reg, byte_next;
    logic          rs_reg, rs_next;
    logic          abort_reg, abort_next;
    logic          ndrv_count_reg, ndrv_count_next;
    logic          drv_rdy_reg, drv_rdy_next;
    logic          drv_abort_reg, drv_abort_next;
    logic          lcd_e_reg, lcd_e_next;
    logic          lcd_rs_reg, lcd_rs_next;
    logic          lcd_rw_reg;
    logic [7:0]    lcd_db_reg, lcd_db_next;
    strobe_phase_t phase_cur, phase_nxt;
    logic          nib_advance, nib_e_next;

    assign phase_cur = phase_of(state_reg);
    assign phase_nxt = phase_of(state_next);

    controller_nibble_strobe #(
        .NFLAGS (NFLAGS)
    ) u_strobe (
        .phase      (phase_cur),
        .phase_next (phase_nxt),
        .flags      (flags_in),
        .cnt_clear  (ndrv_count_reg),
        .advance    (nib_advance),
        .e_next     (nib_e_next)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            byte_reg       <= 8'h00;
            rs_reg         <= 1'b0;
            abort_reg      <= 1'b0;
            ndrv_count_reg <= 1'b1;
            drv_rdy_reg    <= 1'b0;
            drv_abort_reg  <= 1'b0;
            lcd_e_reg      <= 1'b0;
            lcd_rs_reg     <= 1'b0;
            lcd_rw_reg     <= 1'b0;
            lcd_db_reg     <= 8'h00;
        end else begin
            state_reg      <= state_next;
            byte_reg       <= byte_next;
            rs_reg         <= rs_next;
            abort_reg      <= abort_next;
            ndrv_count_reg <= ndrv_count_next;
            drv_rdy_reg    <= drv_rdy_next;
            drv_abort_reg  <= drv_abort_next;
            lcd_e_reg      <= lcd_e_next;
            lcd_rs_reg     <= lcd_rs_next;
            lcd_rw_reg     <= 1'b0;
            lcd_db_reg     <= lcd_db_next;
        end
    end

    // Next state, byte latch and abort flag
    always_comb begin
        state_next = state_reg;
        byte_next  = byte_reg;
        rs_next    = rs_reg;
        abort_next = abort_reg;
        case (state_reg)
            IDLE: begin
                if (enable && sel_data != UNUSED_DATA) begin
                    state_next = SETUP_H;
                    byte_next  = data_in;
                    rs_next    = sel_data[1];
                end
            end
            SETUP_H: if (nib_advance) state_next = EHI_H;
            EHI_H:   if (nib_advance) state_next = ELO_H;
            ELO_H:   if (nib_advance) state_next = (MODE == 1) ? SETUP_L : EXEC;
            SETUP_L: if (nib_advance) state_next = EHI_L;
            EHI_L:   if (nib_advance) state_next = ELO_L;
            ELO_L:   if (nib_advance) state_next = EXEC;
            EXEC:    if (flags_in[F_42US] && !ndrv_count_reg) state_next = DONE;
            DONE:    state_next = RELEASE;
            RELEASE: begin
                // Parking here until enable falls keeps a held enable from
                // resending the same byte.
                if (!enable) begin
                    state_next = IDLE;
                    abort_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        // A lost enable is remembered but the transfer is completed so the
        // LCD never stays half-way through a byte.
        if (!enable && (state_reg inside {SETUP_H, EHI_H, ELO_H, SETUP_L,
                                          EHI_L, ELO_L, EXEC})) begin
            abort_next = 1'b1;
        end
    end

    // Registered output values for the state being entered
    always_comb begin
        // Clear the counter on every state change and in untimed states
        ndrv_count_next = (state_next != state_reg) ||
                          (state_next inside {IDLE, DONE, RELEASE});
        drv_rdy_next    = (state_next == DONE) && !abort_next;
        drv_abort_next  = (state_next == DONE) && abort_next;
        lcd_e_next      = nib_e_next;
        lcd_rs_next     = rs_next;
        lcd_db_next     = lcd_db_reg;
        if (state_reg == IDLE && state_next == SETUP_H) begin
            lcd_db_next = (MODE == 1) ? {byte_next[7:4], 4'h0} : byte_next;
        end else if (state_reg == ELO_H && state_next == SETUP_L) begin
            lcd_db_next = {byte_reg[3:0], 4'h0};
        end
    end

    assign ndrv_count = ndrv_count_reg;
    assign drv_rdy    = drv_rdy_reg;
    assign drv_abort  = drv_abort_reg;
    assign lcd_e      = lcd_e_reg;
    assign lcd_rs     = lcd_rs_reg;
    assign lcd_rw     = lcd_rw_reg;
    assign lcd_db     = lcd_db_reg;

endmodule

// File: tb/tb_controller_driver.sv
// tb_controller_driver
// Two driver instances (index 0: 4-bit bus, index 1: 8-bit bus), each with
// its own delay-counter model. Stimulus pushes the expected bus events
// (E strobes with bus contents, then ready or abort with its cycle) into a
// queue; a monitor pops and compares whenever a DUT shows an event.
module tb_controller_driver;
    import controller_driver_pkg::*;

    localparam int NF     = 7;
    localparam int CP_40  = 2;
    localparam int CP_250 = 13;
    localparam int CP_42  = 210;

    typedef struct {
        int         inst;
        int         kind;   // 0 = E strobe, 1 = ready, 2 = abort
        logic [7:0] db;
        logic       rs;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  exp_q[$];

    logic       en   [2];
    logic [1:0] sel  [2];
    logic [7:0] din  [2];
    logic       ndrv [2];
    logic       rdy  [2];
    logic       abt  [2];
    logic       e    [2];
    logic       rs   [2];
    logic       rw   [2];
    logic [7:0] db   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0]   cnt;
        logic [NF-1:0] flags;
        // Shared delay counter: held at 0 while ndrv_count is high
        always @(posedge clk) begin
            if (ndrv[gi]) cnt <= 0;
            else          cnt <= cnt + 1;
        end
        assign flags = {cnt >= CP_40, cnt >= CP_250, cnt >= CP_42, cnt >= 500,
                        cnt >= 1600, cnt >= 4000, cnt >= 9000};
        controller_driver #(.NFLAGS(NF), .MODE(gi == 0 ? 1 : 0)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .enable     (en[gi]),
            .sel_data   (sel[gi]),
            .data_in    (din[gi]),
            .flags_in   (flags),
            .ndrv_count (ndrv[gi]),
            .drv_rdy    (rdy[gi]),
            .drv_abort  (abt[gi]),
            .lcd_e      (e[gi]),
            .lcd_rs     (rs[gi]),
            .lcd_rw     (rw[gi]),
            .lcd_db     (db[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from the edge that samples enable to the edge entering DONE:
    // each timed state lasts its checkpoint plus two cycles.
    function automatic int latency(input int inst);
        int per_nib = (CP_40 + 2) + 2 * (CP_250 + 2);
        return (inst == 0 ? 2 : 1) * per_nib + CP_42 + 2;
    endfunction

    task automatic got(input int i, input int kind, input logic [7:0] dbv, input logic rsv);
        ev_t x;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: inst %0d kind %0d, expected none (cycle %0d)", i, kind, cyc);
        end else begin
            tests--;
            x = exp_q.pop_front();
            check("event_inst", i, x.inst);
            check("event_kind", kind, x.kind);
            check("lcd_rw", rw[i], 0);
            if (kind == 0) begin
                check("strobe_db", dbv, x.db);
                check("strobe_rs", rsv, x.rs);
            end else begin
                check("done_cycle", cyc, x.cyc);
            end
        end
    endtask

    task automatic monitor();
        bit prev_e [2];
        int hi [2];
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    prev_e[i] = 1'b0;
                    hi[i] = 0;
                end else begin
                    if (e[i] && !prev_e[i]) begin
                        hi[i] = 1;
                        got(i, 0, db[i], rs[i]);
                    end else if (e[i]) begin
                        hi[i]++;
                    end
                    if (!e[i] && prev_e[i]) check("e_width", hi[i], CP_250 + 2);
                    if (rdy[i]) got(i, 1, db[i], rs[i]);
                    if (abt[i]) got(i, 2, db[i], rs[i]);
                    prev_e[i] = e[i];
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // One byte transfer. abort_at > 0 drops enable that many cycles into
    // the transfer; otherwise enable is held for 'hold' cycles after ready.
    task automatic run_xfer(input int i, input logic [7:0] d, input logic [1:0] s,
                            input int abort_at, input int hold);
        ev_t x;
        x.inst = i; x.kind = 0; x.rs = s[1]; x.cyc = 0;
        if (i == 0) begin
            x.db = {d[7:4], 4'h0}; exp_q.push_back(x);
            x.db = {d[3:0], 4'h0}; exp_q.push_back(x);
        end else begin
            x.db = d; exp_q.push_back(x);
        end
        @(posedge clk); #1;
        x.kind = (abort_at > 0) ? 2 : 1;
        x.cyc  = cyc + 1 + latency(i);
        exp_q.push_back(x);
        en[i] = 1'b1; sel[i] = s; din[i] = d;
        @(posedge clk); #1;
        // Inputs changed after the latch must not affect this byte
        din[i] = 8'($urandom);
        sel[i] = $urandom_range(1, 0) ? EXTERNAL_DATA : INTERNAL_CMD;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1 en[i] = 1'b0;
            wait_drain();
        end else begin
            wait_drain();
            repeat (hold + 1) @(posedge clk);
            #1 check("release_ndrv", ndrv[i], 1);
            en[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 check("idle_ndrv", ndrv[i], 1);
        check("idle_e", e[i], 0);
    endtask

    initial begin
        ev_t x;
        int  i, ab;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; sel[k] = UNUSED_DATA; din[k] = 8'h00;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ndrv", ndrv[k], 1);
            check("rst_rdy", rdy[k], 0);
            check("rst_abort", abt[k], 0);
            check("rst_e", e[k], 0);
            check("rst_rs", rs[k], 0);
            check("rst_rw", rw[k], 0);
            check("rst_db", db[k], 0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Directed cases
        run_xfer(0, SETUP, INTERNAL_CMD, 0, 0);
        run_xfer(0, 8'h41, EXTERNAL_DATA, 0, 0);
        run_xfer(0, 8'h41, EXTERNAL_DATA, 0, 3);
        run_xfer(0, 8'h5A, EXTERNAL_DATA, 8, 0);   // enable lost in EHI_H
        run_xfer(1, CLEAR_CMD, INTERNAL_CMD, 0, 0);
        run_xfer(1, 8'hC3, EXTERNAL_DATA, 20, 0);

        // enable with the unused select code is ignored
        @(posedge clk); #1;
        en[0] = 1'b1; sel[0] = UNUSED_DATA; din[0] = 8'hFF;
        repeat (5) @(posedge clk);
        #1 check("unused_sel_ndrv", ndrv[0], 1);
        check("unused_sel_e", e[0], 0);
        en[0] = 1'b0;

        // Reset during the second nibble's E pulse
        x.inst = 0; x.kind = 0; x.rs = 1'b0; x.cyc = 0;
        x.db = 8'h30; exp_q.push_back(x);
        x.db = 8'hC0; exp_q.push_back(x);
        x.kind = 1; exp_q.push_back(x);
        @(posedge clk); #1;
        en[0] = 1'b1; sel[0] = INTERNAL_CMD; din[0] = 8'h3C;
        for (int n = 0; n < 500 && exp_q.size() > 1; n++) @(negedge clk);
        check("reach_ehi_l", exp_q.size(), 1);
        @(posedge clk); #1;
        rst = 1'b1; en[0] = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("rst_mid_e", e[0], 0);
        check("rst_mid_db", db[0], 0);
        check("rst_mid_ndrv", ndrv[0], 1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (60) @(posedge clk);
        #1 check("post_rst_ndrv", ndrv[0], 1);

        // Randomised transfers
        for (int t = 0; t < 16; t++) begin
            i  = $urandom_range(1, 0);
            ab = ($urandom_range(3, 0) == 0) ? $urandom_range(latency(i) - 10, 1) : 0;
            run_xfer(i, 8'($urandom), $urandom_range(1, 0) ? EXTERNAL_DATA : INTERNAL_CMD,
                     ab, $urandom_range(3, 0));
        end

        repeat (5) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
